// File: rtl/alu_32bit.sv
// Registered 32-bit MIPS ALU: AND/OR/ADD/SUB/SLT with carry, overflow and zero flags.
// Optional `ALU_EXT_OPS_EN enables XOR/NOR/SLTU on the otherwise reserved opcodes.
module alu_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  OP,
  output logic        out_valid,
  output logic [31:0] result,
  output logic        c_out,
  output logic        V,
  output logic        Z
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [32:0] sum;
  logic [32:0] diff;
  logic        v_add;
  logic        v_sub;

  // A single adder shape for both: subtraction is A + ~B + 1, carry-out means no borrow.
  assign sum   = {1'b0, A} + {1'b0, B};
  assign diff  = {1'b0, A} + {1'b0, ~B} + 33'd1;
  assign v_add = (A[31] == B[31]) && (sum[31] != A[31]);
  assign v_sub = (A[31] != B[31]) && (diff[31] != A[31]);

  logic [31:0] result_next;
  logic        c_next;
  logic        v_next;

  always_comb begin
    result_next = 32'd0;
    c_next      = 1'b0;
    v_next      = 1'b0;
    case (OP)
      OP_AND: result_next = A & B;
      OP_OR:  result_next = A | B;
      OP_ADD: begin
        result_next = sum[31:0];
        c_next      = sum[32];
        v_next      = v_add;
      end
      OP_SUB: begin
        result_next = diff[31:0];
        c_next      = diff[32];
        v_next      = v_sub;
      end
      OP_SLT: result_next = {31'd0, diff[31] ^ v_sub};
`ifdef ALU_EXT_OPS_EN
      OP_XOR:  result_next = A ^ B;
      OP_NOR:  result_next = ~(A | B);
      OP_SLTU: result_next = {31'd0, ~diff[32]};
`else
      OP_XOR, OP_NOR, OP_SLTU: result_next = 32'd0;
`endif
      default: result_next = 32'd0;
    endcase
  end

  // Result and flags only move on an accepted operation; otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= 32'd0;
      c_out     <= 1'b0;
      V         <= 1'b0;
      Z         <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= result_next;
        c_out  <= c_next;
        V      <= v_next;
        Z      <= (result_next == 32'd0);
      end
    end
  end

endmodule

// File: tb/tb_alu_32bit.sv
// Self-checking bench for alu_32bit: directed test-plan vectors, reset/hold cases and random ops.
module tb_alu_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  OP;
  logic        out_valid;
  logic [31:0] result;
  logic        c_out;
  logic        V;
  logic        Z;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_32bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .out_valid (out_valid),
    .result    (result),
    .c_out     (c_out),
    .V         (V),
    .Z         (Z)
  );

  always #5 clk = ~clk;

  // Reference model from arithmetic definitions: wide integers, signed compares.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                output logic [31:0] r, output logic c, output logic v);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          s;
    longint unsigned us;
    r = 32'd0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        s  = sa + sb;
        us = ua + ub;
        r  = us[31:0];
        c  = (us >= 64'h1_0000_0000);
        v  = (s != longint'($signed(r)));
      end
      3'd6: begin
        s = sa - sb;
        r = a - b;
        c = (ua >= ub);
        v = (s != longint'($signed(r)));
      end
      3'd7: r = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_EXT_OPS_EN
      3'd3: r = a ^ b;
      3'd4: r = ~(a | b);
      3'd5: r = (ua < ub) ? 32'd1 : 32'd0;
`endif
      default: r = 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  logic [31:0] last_r;
  logic        last_c;
  logic        last_v;

  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    logic [31:0] er;
    logic        ec;
    logic        ev;
    model(a, b, op, er, ec, ev);
    @(negedge clk);
    A = a;
    B = b;
    OP = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    $display("op=%0d A=%h B=%h -> result=%h c=%b V=%b Z=%b (%s)", op, a, b, result, c_out, V, Z, tag);
    check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".result"}, result, er);
    check({tag, ".c_out"}, {31'd0, c_out}, {31'd0, ec});
    check({tag, ".V"}, {31'd0, V}, {31'd0, ev});
    check({tag, ".Z"}, {31'd0, Z}, {31'd0, er == 32'd0});
    last_r = er;
    last_c = ec;
    last_v = ev;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".result"}, result, 32'd0);
    check({tag, ".c_out"}, {31'd0, c_out}, 32'd0);
    check({tag, ".V"}, {31'd0, V}, 32'd0);
    check({tag, ".Z"}, {31'd0, Z}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    A = 32'd0;
    B = 32'd0;
    OP = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors; the model computes every expectation independently.
    issue("and",      32'hAAAAAAAA, 32'h55555555, 3'b000);
    check("and.result_const", result, 32'h00000000);
    issue("or",       32'hAAAAAAAA, 32'h55555555, 3'b001);
    check("or.result_const", result, 32'hFFFFFFFF);
    issue("add_small", 32'h0000000C, 32'h0000000A, 3'b010);
    issue("add_carry", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010);
    check("add_carry.c_const", {31'd0, c_out}, 32'd1);
    issue("add_ovf",  32'h7FFFFFFF, 32'h00000001, 3'b010);
    check("add_ovf.V_const", {31'd0, V}, 32'd1);
    issue("sub",      32'h0000000C, 32'h0000000A, 3'b110);
    issue("sub_eq",   32'h0000000C, 32'h0000000C, 3'b110);
    issue("sub_ovf",  32'h80000000, 32'h00000001, 3'b110);
    issue("sub_borrow", 32'h00000001, 32'h00000002, 3'b110);
    issue("slt_0_m1", 32'h00000000, 32'hFFFFFFFF, 3'b111);
    issue("slt_m1_0", 32'hFFFFFFFF, 32'h00000000, 3'b111);
    check("slt_m1_0.result_const", result, 32'd1);
    issue("slt_ovf",  32'h80000000, 32'h7FFFFFFF, 3'b111);
    issue("rsv_100",  32'h00000000, 32'h00000000, 3'b100);
`ifdef ALU_EXT_OPS_EN
    check("rsv_100.result_const", result, 32'hFFFFFFFF);
`else
    check("rsv_100.result_const", result, 32'h00000000);
`endif
    issue("rsv_011",  32'h12345678, 32'h0F0F0F0F, 3'b011);
    issue("rsv_101",  32'h00000001, 32'hFFFFFFFF, 3'b101);

    // Idle cycle: out_valid drops, result and flags hold.
    @(negedge clk);
    in_valid = 1'b0;
    A = 32'hDEADBEEF;
    OP = 3'b010;
    @(posedge clk);
    #1;
    check("hold.out_valid", {31'd0, out_valid}, 32'd0);
    check("hold.result", result, last_r);
    check("hold.c_out", {31'd0, c_out}, {31'd0, last_c});
    check("hold.V", {31'd0, V}, {31'd0, last_v});

    // Asynchronous reset mid-stream, away from any clock edge.
    issue("pre_reset", 32'h7FFFFFFF, 32'h7FFFFFFF, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("in_reset_issue");
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset.out_valid", {31'd0, out_valid}, 32'd0);
    check("post_reset.result", result, 32'd0);

    // Random back-to-back traffic across all opcodes.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rop;
      ra = $urandom;
      rb = (i % 8 == 0) ? ra : $urandom;
      if (i % 16 == 1) rb = {ra[31], ~ra[30:0]};
      rop = 3'($urandom_range(0, 7));
      issue("rand", ra, rb, rop);
    end

    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("final_idle.out_valid", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
